// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: shares the memory bus between the CPU and the OAM DMA engine.
// Define OAM_DMA_RESTART_EN to let FF46 writes restart a transfer in progress.
module oam_dma_arbiter #(
   parameter int          DMA_LEN      = 160,
   parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_r_addr,
   input  logic [15:0] cpu_w_addr,
   input  logic [7:0]  cpu_w_data,
   input  logic        cpu_w_wen,
   output logic [7:0]  cpu_r_data,
   output logic [15:0] mem_r_addr,
   input  logic [7:0]  mem_r_data,
   output logic [15:0] mem_w_addr,
   output logic [7:0]  mem_w_data,
   output logic        mem_w_wen,
   output logic        dma_active
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] READ  = 2'd2;
   localparam logic [1:0] WRITE = 2'd3;
   localparam logic [7:0] LAST  = 8'(DMA_LEN - 1);

   logic [1:0] state;
   logic [7:0] src_hi, src_eff, idx, dma_data;
   logic       idle, hram_r, hram_w, reg_r, reg_w, cpu_hram_w, dma_r, dma_w, restart;

   assign idle       = state == IDLE;
   assign dma_active = !idle;
   assign hram_r     = cpu_r_addr >= 16'hFF80 && cpu_r_addr <= 16'hFFFE;
   assign hram_w     = cpu_w_addr >= 16'hFF80 && cpu_w_addr <= 16'hFFFE;
   assign reg_r      = cpu_r_addr == DMA_REG_ADDR;
   assign reg_w      = cpu_w_wen && cpu_w_addr == DMA_REG_ADDR;
   assign cpu_hram_w = cpu_w_wen && hram_w;
   // echo RAM E000-FDFF mirrors C000-DDFF
   assign src_eff    = src_hi >= 8'hE0 ? src_hi - 8'h20 : src_hi;
`ifdef OAM_DMA_RESTART_EN
   assign restart    = reg_w && !idle;
`else
   assign restart    = 1'b0;
`endif
   // CPU HRAM traffic always wins; the DMA simply waits for a free port
   assign dma_r      = state == READ && !hram_r;
   assign dma_w      = state == WRITE && !cpu_hram_w && !restart;

   always_comb begin
      cpu_r_data = reg_r ? src_hi : (idle || hram_r) ? mem_r_data : 8'hFF;
      mem_r_addr = dma_r ? {src_eff, idx} : cpu_r_addr;
      mem_w_addr = dma_w ? {8'hFE, idx} : cpu_w_addr;
      mem_w_data = dma_w ? dma_data : cpu_w_data;
      mem_w_wen  = !rst && (dma_w || (idle ? cpu_w_wen && !reg_w : cpu_hram_w));
   end

   always_ff @(posedge clk)
      if (rst) begin
         state    <= IDLE;
         src_hi   <= 8'h00;
         idx      <= 8'h00;
         dma_data <= 8'h00;
      end else if (reg_w && (idle || restart)) begin
         src_hi <= cpu_w_data;
         idx    <= 8'h00;
         state  <= START;
      end else if (state == START) begin
         state <= READ;
      end else if (dma_r) begin
         dma_data <= mem_r_data;
         state    <= WRITE;
      end else if (dma_w) begin
         state <= idx == LAST ? IDLE : READ;
         idx   <= idx == LAST ? idx : idx + 8'd1;
      end
endmodule
